image_stream_proc: RTL and testbench
====================================

# image_stream_proc

Streaming, parametrised successor to the frame-buffer image reader. It accepts one RGB pixel per handshake in raster order and applies a run-time-selected point operation: pass, saturating brightness add/sub, grayscale, threshold or invert. It also generates output write coordinates, optionally rotated 90° clockwise, and returns pixels through a 2-stage pipeline with valid/ready backpressure. It sits between a pixel source (file reader or DMA) and the image writer.

## Interface
- DW, 8, bits per colour channel
- WIDTH, 768, input frame width in pixels
- HEIGHT, 512, input frame height in pixels
- CW, 11, coordinate width; must satisfy 2^CW ≥ max(WIDTH, HEIGHT)

Ports:
- HCLK  in  1  clock; all logic on rising edge
- HRESET  in  1  synchronous reset, active-high
- start  in  1  frame start pulse; sampled only in IDLE
- cfg_mode  in  3  0 pass, 1 bright add, 2 bright sub, 3 gray, 4 threshold, 5 invert, 6/7 pass
- cfg_value  in  DW  brightness offset
- cfg_threshold  in  DW  threshold level
- cfg_rotate  in  1  1 = rotate 90° clockwise
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts input pixel
- in_r, in_g, in_b  in  DW each  input pixel
- out_valid  out  1  output pixel valid
- out_ready  in  1  sink accepts output
- out_r, out_g, out_b  out  DW each  processed pixel
- out_row, out_col  out  CW each  write coordinates of out pixel
- out_last  out  1  final pixel of frame, qualified by out_valid
- out_width, out_height  out  32 each  output frame dimensions
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse after last output handshake

## Operation
- FSM IDLE → RUN on start. RUN → DRAIN on the edge accepting pixel WIDTH*HEIGHT−1. DRAIN → IDLE on the edge where out_last is handshaken.
- cfg_* latched on the start edge; held constant for the frame.
- out_width/out_height latched at start: WIDTH/HEIGHT if cfg_rotate=0, else HEIGHT/WIDTH.
- Input counters row, col: reset to 0 at start. On each input handshake, col increments; at col=WIDTH−1, col←0 and row++.
- Coordinates travel with their pixel. rotate=0: out_row=row, out_col=col. rotate=1: out_row=col, out_col=HEIGHT−1−row.
- MAX = 2^DW−1. gray = floor((r+g+b)/3), sum computed at DW+2 bits.
- Mode 1: each ch = min(ch+value, MAX), computed at DW+1 bits.
- Mode 2: each ch = max(ch−value, 0).
- Mode 3: all channels = gray.
- Mode 4: all channels = MAX if gray > threshold, else 0.
- Mode 5: each ch = MAX−ch.
- Modes 0, 6, 7: channels unchanged.
- Pipeline: S1 registers input plus coordinates, last flag and the sum. S2 registers the result, which drives out_*.
- advance = !out_valid || out_ready. When advance is low, S1 and S2 hold.
- in_ready = (state==RUN) && advance.
- start outside IDLE is ignored. in_valid outside RUN is ignored.

## Timing
- Reset: state IDLE. in_ready, out_valid, out_last, busy, done = 0. out_r/g/b, out_row, out_col = 0. out_width/out_height = 0. Counters and pipeline valids cleared.
- HRESET mid-frame: frame abandoned, the state above is reached on that edge, and no done pulse is generated.
- in_ready rises the cycle after the start edge.
- Latency: pixel accepted at edge N appears on out_* after edge N+1 without stall. Throughput is 1 pixel/cycle.
- A pixel accepted at edge N is registered into S1 at edge N.
- Under backpressure, out_* are stable while out_valid && !out_ready; no pixel is dropped or duplicated.
- done is high for exactly the cycle after the out_last handshake. busy falls on the same edge as done rises.
- A new start is accepted on the first IDLE cycle, which may be the cycle done is high.

## Test plan
- Pass, WIDTH=4, HEIGHT=3, rotate=0, out_ready=1: 12 pixels streamed → identical data out. Coordinates run (0,0)…(2,3). out_last only on the 12th pixel. First out_valid 2 cycles after the first handshake. done pulse once.
- Brightness, value=100: mode 1 on (200,50,155) → (255,150,255). Mode 2 on (60,100,255) → (0,0,155).
- Gray/threshold: mode 3 on (10,20,31) → (20,20,20). Mode 4, threshold=90: gray 90 → (0,0,0), gray 91 → (255,255,255). Mode 5 on (0,128,255) → (255,127,0).
- Rotate, WIDTH=4, HEIGHT=3: input (0,0) → out (0,2); (2,3) → (3,0). out_width=3, out_height=4.
- Backpressure: out_ready toggled randomly, 3-cycle stalls → in_ready low during stalls, out_* stable, all 12 pixels in order.
- HRESET asserted after pixel 5, then new start: outputs reset, no done pulse; second frame completes with fresh coordinates from (0,0). start pulsed during RUN is ignored.

Source files
------------

// File: rtl/image_stream_proc_if.sv
// Pixel stream bundle: input pixel handshake and output pixel/coordinate handshake.
// master = pixel source/sink side, slave = the processing block.
`timescale 1ns/1ps
interface image_stream_proc_if #(
  parameter int DW = 8,
  parameter int CW = 11
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_r;
  logic [DW-1:0] in_g;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_g;
  logic [DW-1:0] out_b;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;

  modport master (
    output in_valid, in_r, in_g, in_b, out_ready,
    input  in_ready, out_valid, out_r, out_g, out_b, out_row, out_col, out_last
  );

  modport slave (
    input  in_valid, in_r, in_g, in_b, out_ready,
    output in_ready, out_valid, out_r, out_g, out_b, out_row, out_col, out_last
  );
endinterface

// File: rtl/image_stream_proc.sv
// Streaming RGB point-operation engine with raster coordinate generation,
// optional 90-degree clockwise rotation and a 2-stage valid/ready pipeline.
`timescale 1ns/1ps
module image_stream_proc #(
  parameter int DW     = 8,
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int CW     = 11
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                start,
  input  logic [2:0]          cfg_mode,
  input  logic [DW-1:0]       cfg_value,
  input  logic [DW-1:0]       cfg_threshold,
  input  logic                cfg_rotate,
  image_stream_proc_if.slave  stream,
  output logic [31:0]         out_width,
  output logic [31:0]         out_height,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int            SW  = DW + 2;
  localparam logic [DW-1:0] MAX = '1;

  state_t        state;
  logic [2:0]    mode;
  logic [DW-1:0] value;
  logic [DW-1:0] threshold;
  logic          rotate;
  logic [CW-1:0] row;
  logic [CW-1:0] col;

  logic          s1_valid;
  logic [DW-1:0] s1_r, s1_g, s1_b;
  logic [CW-1:0] s1_row, s1_col;
  logic          s1_last;
  logic [SW-1:0] s1_sum;

  logic          out_valid_q;
  logic [DW-1:0] out_r_q, out_g_q, out_b_q;
  logic [CW-1:0] out_row_q, out_col_q;
  logic          out_last_q;

  logic          advance;
  logic          accept;
  logic          in_last;
  logic          last_hs;
  logic [CW-1:0] map_row, map_col;
  logic [DW-1:0] gray;
  logic [DW-1:0] res_r, res_g, res_b;

  assign advance         = !out_valid_q || stream.out_ready;
  assign stream.in_ready = (state == RUN) && advance;
  assign accept          = stream.in_valid && stream.in_ready;
  assign in_last         = (row == CW'(HEIGHT - 1)) && (col == CW'(WIDTH - 1));
  assign last_hs         = out_valid_q && stream.out_ready && out_last_q;

  assign stream.out_valid = out_valid_q;
  assign stream.out_r     = out_r_q;
  assign stream.out_g     = out_g_q;
  assign stream.out_b     = out_b_q;
  assign stream.out_row   = out_row_q;
  assign stream.out_col   = out_col_q;
  assign stream.out_last  = out_last_q;

  function automatic logic [DW-1:0] sat_add(logic [DW-1:0] a, logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? MAX : s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] sat_sub(logic [DW-1:0] a, logic [DW-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  always_comb begin
    map_row = row;
    map_col = col;
    if (rotate) begin
      map_row = col;
      map_col = CW'(HEIGHT - 1) - row;
    end
  end

  assign gray = DW'(s1_sum / SW'(3));

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    res_r = s1_r;
    res_g = s1_g;
    res_b = s1_b;
    case (mode)
      3'd1: begin
        res_r = sat_add(s1_r, value);
        res_g = sat_add(s1_g, value);
        res_b = sat_add(s1_b, value);
      end
      3'd2: begin
        res_r = sat_sub(s1_r, value);
        res_g = sat_sub(s1_g, value);
        res_b = sat_sub(s1_b, value);
      end
      3'd3: begin
        res_r = gray;
        res_g = gray;
        res_b = gray;
      end
      3'd4: begin
        res_r = (gray > threshold) ? MAX : '0;
        res_g = res_r;
        res_b = res_r;
      end
      3'd5: begin
        res_r = MAX - s1_r;
        res_g = MAX - s1_g;
        res_b = MAX - s1_b;
      end
      default: ;
    endcase
  end

  // Frame control: configuration capture, raster counters and state.
  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (HRESET) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mode       <= '0;
      value      <= '0;
      threshold  <= '0;
      rotate     <= 1'b0;
      row        <= '0;
      col        <= '0;
      out_width  <= '0;
      out_height <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state      <= RUN;
          busy       <= 1'b1;
          mode       <= cfg_mode;
          value      <= cfg_value;
          threshold  <= cfg_threshold;
          rotate     <= cfg_rotate;
          row        <= '0;
          col        <= '0;
          out_width  <= cfg_rotate ? 32'(HEIGHT) : 32'(WIDTH);
          out_height <= cfg_rotate ? 32'(WIDTH)  : 32'(HEIGHT);
        end
        RUN: if (accept && in_last) state <= DRAIN;
        DRAIN: if (last_hs) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        if (col == CW'(WIDTH - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Two-stage pipeline; both stages freeze together while the sink stalls.
  always_ff @(posedge HCLK) begin
    // NOTE: datapath registers are reset too, because the output pixel fields must read zero after reset.
    if (HRESET) begin
      s1_valid    <= 1'b0;
      s1_r        <= '0;
      s1_g        <= '0;
      s1_b        <= '0;
      s1_row      <= '0;
      s1_col      <= '0;
      s1_last     <= 1'b0;
      s1_sum      <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_g_q     <= '0;
      out_b_q     <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
    end else if (advance) begin
      s1_valid <= accept;
      if (accept) begin
        s1_r    <= stream.in_r;
        s1_g    <= stream.in_g;
        s1_b    <= stream.in_b;
        s1_row  <= map_row;
        s1_col  <= map_col;
        s1_last <= in_last;
        s1_sum  <= SW'(stream.in_r) + SW'(stream.in_g) + SW'(stream.in_b);
      end
      out_valid_q <= s1_valid;
      out_last_q  <= s1_valid && s1_last;
      if (s1_valid) begin
        out_r_q   <= res_r;
        out_g_q   <= res_g;
        out_b_q   <= res_b;
        out_row_q <= s1_row;
        out_col_q <= s1_col;
      end
    end
  end

endmodule

// File: tb/tb_image_stream_proc.sv
// Directed bench for image_stream_proc on a 4x3 frame with a scoreboard queue
// filled at each input handshake and drained at each output handshake.
`timescale 1ns/1ps
module tb_image_stream_proc;
  localparam int DW = 8, WIDTH = 4, HEIGHT = 3, CW = 11, NPIX = WIDTH * HEIGHT;

  typedef struct packed {
    logic [23:0]   rgb;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          last;
  } exp_t;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          start;
  logic [2:0]    cfg_mode;
  logic [DW-1:0] cfg_value;
  logic [DW-1:0] cfg_threshold;
  logic          cfg_rotate;
  logic [31:0]   out_width, out_height;
  logic          busy, done;

  image_stream_proc_if #(.DW(DW), .CW(CW)) bus ();

  image_stream_proc #(.DW(DW), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CW(CW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .cfg_mode(cfg_mode),
    .cfg_value(cfg_value), .cfg_threshold(cfg_threshold), .cfg_rotate(cfg_rotate),
    .stream(bus), .out_width(out_width), .out_height(out_height),
    .busy(busy), .done(done)
  );

  always #5 HCLK = ~HCLK;

  exp_t        sb[$];
  int          tests = 0, fails = 0, cyc = 0, done_count = 0, out_idx = 0;
  int          first_valid_cyc = -1, first_acc_edge = -1, frame_id = 0, stall_left = 0;
  bit          mon_en = 1'b0, bp_en = 1'b0, prev_stall = 1'b0;
  logic [46:0] prev_out;
  logic [7:0]  px_r[NPIX], px_g[NPIX], px_b[NPIX];
  logic [23:0] ex_rgb[NPIX];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model(int mode, int v, int t, int r, int g, int b);
    int c[3];
    int o[3];
    int gr;
    c[0] = r; c[1] = g; c[2] = b;
    gr = (r + g + b) / 3;
    for (int k = 0; k < 3; k++) begin
      case (mode)
        1: o[k] = (c[k] + v > 255) ? 255 : c[k] + v;
        2: o[k] = (c[k] - v < 0) ? 0 : c[k] - v;
        3: o[k] = gr;
        4: o[k] = (gr > t) ? 255 : 0;
        5: o[k] = 255 - c[k];
        default: o[k] = c[k];
      endcase
    end
    return {8'(o[0]), 8'(o[1]), 8'(o[2])};
  endfunction

  task automatic fill(int mode, int v, int t);
    for (int i = 0; i < NPIX; i++) begin
      px_r[i] = 8'($urandom);
      px_g[i] = 8'($urandom);
      px_b[i] = 8'($urandom);
      ex_rgb[i] = model(mode, v, t, int'(px_r[i]), int'(px_g[i]), int'(px_b[i]));
    end
  endtask

  task automatic set_px(int i, logic [23:0] p, logic [23:0] e);
    {px_r[i], px_g[i], px_b[i]} = p;
    ex_rgb[i] = e;
  endtask

  always @(posedge HCLK) cyc <= cyc + 1;

  // Sink: always ready, or random ready with 3-cycle stalls.
  always @(posedge HCLK) begin
    #1;
    if (!bp_en) begin
      bus.out_ready = 1'b1;
      stall_left = 0;
    end else if (stall_left > 0) begin
      bus.out_ready = 1'b0;
      stall_left--;
    end else if ($urandom_range(0, 2) == 0) begin
      bus.out_ready = 1'b0;
      stall_left = 2;
    end else begin
      bus.out_ready = 1'b1;
    end
  end

  // Output monitor: scoreboard pop, stall stability, done pulse count.
  always @(negedge HCLK) begin
    exp_t e;
    if (done) done_count++;
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) begin
        check("stall_hold_valid", 64'(bus.out_valid), 64'(1));
        check("stall_hold_data",
              64'({bus.out_r, bus.out_g, bus.out_b, bus.out_row, bus.out_col, bus.out_last}),
              64'(prev_out));
      end
      if (bus.out_valid && !bus.out_ready)
        check("stall_in_ready_low", 64'(bus.in_ready), 64'(0));
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check($sformatf("f%0d_px%0d_rgb", frame_id, out_idx),
                64'({bus.out_r, bus.out_g, bus.out_b}), 64'(e.rgb));
          check($sformatf("f%0d_px%0d_pos", frame_id, out_idx),
                64'({bus.out_row, bus.out_col, bus.out_last}), 64'({e.row, e.col, e.last}));
        end
        out_idx++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out = {bus.out_r, bus.out_g, bus.out_b, bus.out_row, bus.out_col, bus.out_last};
    end
  end

  task automatic run_frame(logic [2:0] mode, logic [7:0] value, logic [7:0] thr,
                           logic rot, int n_send, bit pulse_start);
    int   d0;
    bit   accepted;
    bit   got;
    exp_t e;
    frame_id++;
    out_idx = 0;
    first_valid_cyc = -1;
    first_acc_edge = -1;
    d0 = done_count;
    @(negedge HCLK);
    check($sformatf("f%0d_idle_in_ready", frame_id), 64'(bus.in_ready), 64'(0));
    @(posedge HCLK); #1;
    start = 1'b1; cfg_mode = mode; cfg_value = value; cfg_threshold = thr; cfg_rotate = rot;
    @(posedge HCLK); #1;
    // Scramble config after the start edge: the frame must use the latched copy.
    start = 1'b0; cfg_mode = 3'($urandom); cfg_value = 8'($urandom);
    cfg_threshold = 8'($urandom); cfg_rotate = ~rot;
    @(negedge HCLK);
    check($sformatf("f%0d_busy", frame_id), 64'(busy), 64'(1));
    check($sformatf("f%0d_in_ready_rise", frame_id), 64'(bus.in_ready), 64'(1));
    check($sformatf("f%0d_out_width", frame_id), 64'(out_width), rot ? 64'(HEIGHT) : 64'(WIDTH));
    check($sformatf("f%0d_out_height", frame_id), 64'(out_height), rot ? 64'(WIDTH) : 64'(HEIGHT));
    for (int i = 0; i < n_send; i++) begin
      @(posedge HCLK); #1;
      bus.in_valid = 1'b1;
      bus.in_r = px_r[i]; bus.in_g = px_g[i]; bus.in_b = px_b[i];
      start = pulse_start && (i == 6);
      accepted = 1'b0;
      for (int w = 0; w < 100 && !accepted; w++) begin
        @(negedge HCLK);
        if (bus.in_ready) accepted = 1'b1;
      end
      check($sformatf("f%0d_accept_%0d", frame_id, i), 64'(accepted), 64'(1));
      if (!accepted) begin
        bus.in_valid = 1'b0;
        start = 1'b0;
        return;
      end
      if (i == 0) first_acc_edge = cyc + 1;
      e.rgb  = ex_rgb[i];
      e.row  = rot ? CW'(i % WIDTH) : CW'(i / WIDTH);
      e.col  = rot ? CW'(HEIGHT - 1 - i / WIDTH) : CW'(i % WIDTH);
      e.last = (i == NPIX - 1);
      sb.push_back(e);
    end
    @(posedge HCLK); #1;
    bus.in_valid = 1'b0;
    start = 1'b0;
    if (n_send < NPIX) return;
    got = 1'b0;
    for (int w = 0; w < 200 && !got; w++) begin
      @(negedge HCLK);
      if (done) got = 1'b1;
    end
    check($sformatf("f%0d_done_seen", frame_id), 64'(got), 64'(1));
    check($sformatf("f%0d_busy_at_done", frame_id), 64'(busy), 64'(0));
    @(negedge HCLK);
    check($sformatf("f%0d_done_one_cycle", frame_id), 64'(done), 64'(0));
    check($sformatf("f%0d_done_count", frame_id), 64'(done_count - d0), 64'(1));
    check($sformatf("f%0d_sb_empty", frame_id), 64'(sb.size()), 64'(0));
    check($sformatf("f%0d_out_count", frame_id), 64'(out_idx), 64'(NPIX));
    check($sformatf("f%0d_latency", frame_id), 64'(first_valid_cyc), 64'(first_acc_edge + 1));
  endtask

  initial begin
    int d0;
    HRESET = 1'b1; start = 1'b0;
    cfg_mode = '0; cfg_value = '0; cfg_threshold = '0; cfg_rotate = 1'b0;
    bus.in_valid = 1'b0; bus.in_r = '0; bus.in_g = '0; bus.in_b = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_last", 64'(bus.out_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rgb", 64'({bus.out_r, bus.out_g, bus.out_b}), 64'(0));
    check("rst_pos", 64'({bus.out_row, bus.out_col}), 64'(0));
    check("rst_dims", 64'({out_width, out_height}), 64'(0));
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    mon_en = 1'b1;

    // Pass-through, with a start pulse during RUN that must be ignored.
    fill(0, 0, 0);
    run_frame(3'd0, 8'd0, 8'd0, 1'b0, NPIX, 1'b1);

    fill(1, 100, 0);
    set_px(0, {8'd200, 8'd50, 8'd155}, {8'd255, 8'd150, 8'd255});
    run_frame(3'd1, 8'd100, 8'd0, 1'b0, NPIX, 1'b0);

    fill(2, 100, 0);
    set_px(0, {8'd60, 8'd100, 8'd255}, {8'd0, 8'd0, 8'd155});
    run_frame(3'd2, 8'd100, 8'd0, 1'b0, NPIX, 1'b0);

    fill(3, 0, 0);
    set_px(0, {8'd10, 8'd20, 8'd31}, {8'd20, 8'd20, 8'd20});
    run_frame(3'd3, 8'd0, 8'd0, 1'b0, NPIX, 1'b0);

    fill(4, 0, 90);
    set_px(0, {8'd90, 8'd91, 8'd89}, 24'h000000);
    set_px(1, {8'd91, 8'd92, 8'd91}, 24'hFFFFFF);
    run_frame(3'd4, 8'd0, 8'd90, 1'b0, NPIX, 1'b0);

    fill(5, 0, 0);
    set_px(0, {8'd0, 8'd128, 8'd255}, {8'd255, 8'd127, 8'd0});
    run_frame(3'd5, 8'd0, 8'd0, 1'b0, NPIX, 1'b0);

    // Mode 6 behaves as pass; coordinates rotated.
    fill(6, 0, 0);
    run_frame(3'd6, 8'd0, 8'd0, 1'b1, NPIX, 1'b0);

    bp_en = 1'b1;
    fill(0, 0, 0);
    run_frame(3'd0, 8'd0, 8'd0, 1'b0, NPIX, 1'b0);
    bp_en = 1'b0;

    // Abandon a frame with reset after five pixels.
    fill(7, 0, 0);
    run_frame(3'd7, 8'd0, 8'd0, 1'b0, 5, 1'b0);
    mon_en = 1'b0;
    HRESET = 1'b1;
    d0 = done_count;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    sb.delete();
    @(negedge HCLK);
    check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_rgb_pos", 64'({bus.out_r, bus.out_g, bus.out_b, bus.out_row, bus.out_col, bus.out_last}), 64'(0));
    mon_en = 1'b1;
    @(posedge HCLK); #1;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge HCLK);
      check("idle_in_ready", 64'(bus.in_ready), 64'(0));
      check("idle_out_valid", 64'(bus.out_valid), 64'(0));
    end
    @(posedge HCLK); #1;
    bus.in_valid = 1'b0;
    check("midrst_no_done", 64'(done_count), 64'(d0));

    fill(0, 0, 0);
    run_frame(3'd0, 8'd0, 8'd0, 1'b0, NPIX, 1'b0);

    repeat (2) @(posedge HCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
